// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the DE2 Cortex-M0 bus fabric: transfer
// and response codes, the data-phase slave index and default slave bases.
package ahb_pkg;

  // HTRANS transfer type codes
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP response codes
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default HADDR[31:16] match values
  localparam logic [15:0] DEF_S0_BASE = 16'h0000;
  localparam logic [15:0] DEF_S1_BASE = 16'h2000;
  localparam logic [15:0] DEF_S2_BASE = 16'h5000;
  localparam logic [15:0] DEF_S3_BASE = 16'h5100;

  // Slave owning the current data phase
  typedef enum logic [2:0] {
    SEL_S0  = 3'd0,
    SEL_S1  = 3'd1,
    SEL_S2  = 3'd2,
    SEL_S3  = 3'd3,
    SEL_DEF = 3'd4
  } slave_sel_e;

  // Default-slave error response states
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // NONSEQ and SEQ both carry bit 1 set; IDLE and BUSY need no response
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers sampled NONSEQ/SEQ transfers to unmapped
// space with the two-cycle AHB ERROR response (wait + final cycle).
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic i_hready,
  input  logic i_unmapped,
  input  logic i_active,
  output logic o_ready,
  output logic o_resp
);

  ds_state_e r_state;
  ds_state_e w_state_nxt;
  logic      r_ready;
  logic      r_resp;
  logic      w_ready_nxt;
  logic      w_resp_nxt;
  logic      w_take;

  // An unmapped access is only accepted when the address phase completes
  assign w_take = i_hready & i_unmapped & i_active;

  // Next state, and the ready/resp values that state will present
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b1;
    w_resp_nxt  = HRESP_OKAY;
    case (r_state)
      DS_IDLE: begin
        if (w_take) w_state_nxt = DS_ERR1;
        else        w_state_nxt = DS_IDLE;
      end
      DS_ERR1: w_state_nxt = DS_ERR2;
      DS_ERR2: begin
        if (w_take) w_state_nxt = DS_ERR1;
        else        w_state_nxt = DS_IDLE;
      end
      default: w_state_nxt = DS_IDLE;
    endcase
    case (w_state_nxt)
      DS_IDLE: begin
        w_ready_nxt = 1'b1;
        w_resp_nxt  = HRESP_OKAY;
      end
      DS_ERR1: begin
        w_ready_nxt = 1'b0;
        w_resp_nxt  = HRESP_ERROR;
      end
      DS_ERR2: begin
        w_ready_nxt = 1'b1;
        w_resp_nxt  = HRESP_ERROR;
      end
      default: begin
        w_ready_nxt = 1'b1;
        w_resp_nxt  = HRESP_OKAY;
      end
    endcase
  end

  // State and registered outputs; reset forces ready/OKAY at once
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= DS_IDLE;
      r_ready <= 1'b1;
      r_resp  <= HRESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_resp  <= w_resp_nxt;
    end
  end

  assign o_ready = r_ready;
  assign o_resp  = r_resp;

endmodule

// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder, data-phase read mux and default slave wrapper
// for the single-master DE2 system (program mem, RAM, LED, 7-segment).
module ahb_decode_mux
  import ahb_pkg::*;
#(
  parameter logic [15:0] S0_BASE = DEF_S0_BASE,
  parameter logic [15:0] S1_BASE = DEF_S1_BASE,
  parameter logic [15:0] S2_BASE = DEF_S2_BASE,
  parameter logic [15:0] S3_BASE = DEF_S3_BASE
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic [3:0]  HSEL_S,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  input  logic [31:0] HRDATA_S3,
  input  logic [3:0]  HREADYOUT_S,
  input  logic [3:0]  HRESP_S,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  slave_sel_e r_sel;
  slave_sel_e w_sel_idx;
  logic [3:0] w_hsel;
  logic       w_unmapped;
  logic       w_ds_ready;
  logic       w_ds_resp;
  logic       w_unused_addr;

  // Only the upper address half takes part in decoding
  assign w_unused_addr = ^{HADDR[15:0], HTRANS[0]};

  // Address-phase decode; lowest matching index wins to stay one-hot
  always_comb begin
    w_hsel    = 4'b0000;
    w_sel_idx = SEL_DEF;
    if (HADDR[31:16] == S0_BASE) begin
      w_hsel    = 4'b0001;
      w_sel_idx = SEL_S0;
    end else if (HADDR[31:16] == S1_BASE) begin
      w_hsel    = 4'b0010;
      w_sel_idx = SEL_S1;
    end else if (HADDR[31:16] == S2_BASE) begin
      w_hsel    = 4'b0100;
      w_sel_idx = SEL_S2;
    end else if (HADDR[31:16] == S3_BASE) begin
      w_hsel    = 4'b1000;
      w_sel_idx = SEL_S3;
    end else begin
      w_hsel    = 4'b0000;
      w_sel_idx = SEL_DEF;
    end
  end

  assign w_unmapped = (w_hsel == 4'b0000);
  assign HSEL_S     = w_hsel;

  // Data-phase owner advances only when the previous transfer completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel <= SEL_DEF;
    end else if (HREADY) begin
      r_sel <= w_sel_idx;
    end else begin
      r_sel <= r_sel;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .i_hready   (HREADY),
    .i_unmapped (w_unmapped),
    .i_active   (is_active_trans(HTRANS)),
    .o_ready    (w_ds_ready),
    .o_resp     (w_ds_resp)
  );

  // Return path mux; slave wait states pass straight through
  always_comb begin
    HRDATA = 32'h0000_0000;
    HREADY = w_ds_ready;
    HRESP  = w_ds_resp;
    case (r_sel)
      SEL_S0: begin
        HRDATA = HRDATA_S0;
        HREADY = HREADYOUT_S[0];
        HRESP  = HRESP_S[0];
      end
      SEL_S1: begin
        HRDATA = HRDATA_S1;
        HREADY = HREADYOUT_S[1];
        HRESP  = HRESP_S[1];
      end
      SEL_S2: begin
        HRDATA = HRDATA_S2;
        HREADY = HREADYOUT_S[2];
        HRESP  = HRESP_S[2];
      end
      SEL_S3: begin
        HRDATA = HRDATA_S3;
        HREADY = HREADYOUT_S[3];
        HRESP  = HRESP_S[3];
      end
      SEL_DEF: begin
        HRDATA = 32'h0000_0000;
        HREADY = w_ds_ready;
        HRESP  = w_ds_resp;
      end
      default: begin
        HRDATA = 32'h0000_0000;
        HREADY = w_ds_ready;
        HRESP  = w_ds_resp;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Directed bench for ahb_decode_mux: decode, data-phase mux, slave wait
// states, default-slave ERROR sequencing and asynchronous reset.
module tb_ahb_decode_mux;

  localparam logic [31:0] D_S0 = 32'h0A0A_0000;
  localparam logic [31:0] D_S2 = 32'h0C0C_0002;
  localparam logic [31:0] D_S3 = 32'h0D0D_0003;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [3:0]  HSEL_S;
  logic [31:0] HRDATA_S0;
  logic [31:0] HRDATA_S1;
  logic [31:0] HRDATA_S2;
  logic [31:0] HRDATA_S3;
  logic [3:0]  HREADYOUT_S;
  logic [3:0]  HRESP_S;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  int checks_cnt;
  int errors_cnt;

  ahb_decode_mux dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL_S      (HSEL_S),
    .HRDATA_S0   (HRDATA_S0),
    .HRDATA_S1   (HRDATA_S1),
    .HRDATA_S2   (HRDATA_S2),
    .HRDATA_S3   (HRDATA_S3),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt = checks_cnt + 1;
    if (act !== exp) begin
      errors_cnt = errors_cnt + 1;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic rdy, input logic rsp, input logic [31:0] dat);
    check_val({tag, ".hready"}, {31'd0, HREADY}, {31'd0, rdy});
    check_val({tag, ".hresp"},  {31'd0, HRESP},  {31'd0, rsp});
    check_val({tag, ".hrdata"}, HRDATA, dat);
  endtask

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    HRESETn     = 1'b0;
    HADDR       = 32'h5100_0000;
    HTRANS      = 2'b00;
    HRDATA_S0   = D_S0;
    HRDATA_S1   = 32'h0B0B_0001;
    HRDATA_S2   = D_S2;
    HRDATA_S3   = D_S3;
    HREADYOUT_S = 4'b1111;
    HRESP_S     = 4'b0000;

    // Reset state; decode still live
    next_cycle();
    next_cycle();
    check_val("rst.hsel", {28'd0, HSEL_S}, 32'h0000_0008);
    check_bus("rst", 1'b1, 1'b0, 32'h0000_0000);
    HRESETn = 1'b1;

    // NONSEQ to LED slave
    next_cycle();
    HADDR  = 32'h5000_0000;
    HTRANS = 2'b10;
    #1;
    check_val("led.hsel", {28'd0, HSEL_S}, 32'h0000_0004);
    next_cycle();
    HADDR  = 32'h2000_0004;
    HTRANS = 2'b10;
    #1;
    check_bus("led.data", 1'b1, 1'b0, D_S2);
    check_val("ram.hsel", {28'd0, HSEL_S}, 32'h0000_0002);

    // RAM read with two wait states; next address must not be taken
    next_cycle();
    HREADYOUT_S[1] = 1'b0;
    HADDR  = 32'h5100_0000;
    HTRANS = 2'b00;
    #1;
    check_val("ram.wait1", {31'd0, HREADY}, 32'h0000_0000);
    next_cycle();
    check_val("ram.wait2", {31'd0, HREADY}, 32'h0000_0000);
    next_cycle();
    HREADYOUT_S[1] = 1'b1;
    HRDATA_S1 = 32'hDEAD_BEEF;
    #1;
    check_bus("ram.done", 1'b1, 1'b0, 32'hDEAD_BEEF);

    // Unmapped NONSEQ: ERR1, ERR2, then OKAY from the next slave
    next_cycle();
    HADDR  = 32'h9000_0000;
    HTRANS = 2'b10;
    #1;
    check_val("unm.hsel", {28'd0, HSEL_S}, 32'h0000_0000);
    check_bus("unm.prev", 1'b1, 1'b0, D_S3);
    next_cycle();
    HADDR  = 32'h5000_0000;
    HTRANS = 2'b10;
    #1;
    check_bus("unm.err1", 1'b0, 1'b1, 32'h0000_0000);
    next_cycle();
    check_bus("unm.err2", 1'b1, 1'b1, 32'h0000_0000);
    next_cycle();
    HADDR  = 32'h0000_0000;
    HTRANS = 2'b00;
    #1;
    check_bus("unm.after", 1'b1, 1'b0, D_S2);

    // Back-to-back unmapped NONSEQs, second shown in ERR2
    next_cycle();
    HADDR  = 32'h9000_0000;
    HTRANS = 2'b10;
    next_cycle();
    check_bus("b2b.err1a", 1'b0, 1'b1, 32'h0000_0000);
    next_cycle();
    HADDR  = 32'h9000_1000;
    HTRANS = 2'b10;
    #1;
    check_bus("b2b.err2a", 1'b1, 1'b1, 32'h0000_0000);
    next_cycle();
    HADDR  = 32'h0000_0000;
    HTRANS = 2'b00;
    #1;
    check_bus("b2b.err1b", 1'b0, 1'b1, 32'h0000_0000);
    next_cycle();
    check_bus("b2b.err2b", 1'b1, 1'b1, 32'h0000_0000);
    next_cycle();
    check_bus("b2b.s0", 1'b1, 1'b0, D_S0);

    // IDLE and BUSY to unmapped space are zero-wait OKAY
    HADDR  = 32'h9000_0000;
    HTRANS = 2'b00;
    next_cycle();
    check_bus("idle.unm", 1'b1, 1'b0, 32'h0000_0000);
    HTRANS = 2'b01;
    next_cycle();
    check_bus("busy.unm", 1'b1, 1'b0, 32'h0000_0000);

    // Reset during ERR1 releases the bus immediately
    HTRANS = 2'b11;
    next_cycle();
    check_bus("rsterr.err1", 1'b0, 1'b1, 32'h0000_0000);
    #2;
    HRESETn = 1'b0;
    #1;
    check_bus("rsterr.rst", 1'b1, 1'b0, 32'h0000_0000);
    HTRANS = 2'b00;
    next_cycle();
    HRESETn = 1'b1;
    next_cycle();
    check_bus("rsterr.idle", 1'b1, 1'b0, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_decode_mux.md
# ahb_decode_mux

AHB-Lite address decoder, data-phase read multiplexer and built-in default slave for the single-master Cortex-M0 system on the DE2 board. It sits between the processor's AHB-Lite master port and the four slaves (program memory, data RAM, LED peripheral, 7-segment peripheral). It drives each slave's HSEL, returns the selected slave's HRDATA/HREADYOUT to the master, and answers unmapped accesses with a two-cycle ERROR response.

## Interface
Parameters:
- S0_BASE, 16'h0000, HADDR[31:16] match value for slave 0 (program memory)
- S1_BASE, 16'h2000, match for slave 1 (data RAM)
- S2_BASE, 16'h5000, match for slave 2 (LED)
- S3_BASE, 16'h5100, match for slave 3 (7-segment)

Ports (clock HCLK; reset HRESETn, asynchronous, active-low):
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type
- HSEL_S  out  4  one-hot slave select; bit n goes to slave n
- HRDATA_S0..HRDATA_S3  in  32 each  slave read data
- HREADYOUT_S  in  4  slave ready; bit n comes from slave n
- HRESP_S  in  4  slave response; tie 0 for slaves without HRESP
- HREADY  out  1  muxed ready to master and to every slave's HREADY
- HRDATA  out  32  muxed read data to master
- HRESP  out  1  muxed response to master (0 OKAY, 1 ERROR)

## Operation
- Address decode is combinational: HSEL_S[n] = (HADDR[31:16] == Sn_BASE). If more than one base matches, the lowest index wins, so HSEL_S stays one-hot.
- Unmapped is asserted when no base matches. Unmapped selects the internal default slave.
- Data-phase select register sel_q (values S0..S3, DEF) loads the decode result on every HCLK edge where HREADY = 1, and holds otherwise.
- Output mux is driven by sel_q:
  - Sn selected: HRDATA = HRDATA_Sn, HREADY = HREADYOUT_S[n], HRESP = HRESP_S[n].
  - DEF selected: HRDATA = 32'h0; HREADY and HRESP come from the default-slave FSM.
- Default-slave FSM:
  - States: IDLE, ERR1, ERR2.
  - IDLE -> ERR1 when HREADY = 1, unmapped, and HTRANS[1] = 1 (NONSEQ or SEQ). Otherwise stay in IDLE.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> ERR1 when a new unmapped NONSEQ/SEQ is sampled in that cycle. Otherwise ERR2 -> IDLE.
- Default-slave outputs: IDLE gives ready=1, resp=0. ERR1 gives ready=0, resp=1. ERR2 gives ready=1, resp=1.
- IDLE or BUSY transfers to unmapped space get a zero-wait OKAY response.
- During ERR1, changes on HADDR/HTRANS are ignored because HREADY = 0. Master cancellation to IDLE is legal and takes effect after ERR2.

## Timing
- Reset values: sel_q = DEF, FSM = IDLE, HREADY = 1, HRESP = 0, HRDATA = 0. HSEL_S follows HADDR combinationally, even during reset.
- HSEL_S has zero latency from HADDR (address phase).
- HRDATA/HREADY/HRESP switch source one cycle after the address phase completes, i.e. in the data phase.
- Slave wait states propagate combinationally. sel_q is frozen while the selected slave holds HREADYOUT low.
- An ERROR response to an unmapped access always lasts exactly 2 cycles: 1 wait cycle plus the final cycle.
- Back-to-back unmapped accesses produce repeating ERR1, ERR2, ERR1, ERR2 with no IDLE gap.
- Reset mid-ERROR returns the FSM to IDLE and HREADY to 1 immediately, asynchronously.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS codes (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11)
  - HRESP codes
  - the slave index enum (S0..S3, DEF)
  - default base-address constants
- Sub-module ahb_default_slave holds the IDLE/ERR1/ERR2 FSM and produces ready/resp. The top level holds the decode, sel_q and the output mux.

## Test plan
- Reset: hold HRESETn = 0 with HADDR = 32'h5100_0000 -> HSEL_S = 4'b1000, HREADY = 1, HRESP = 0, HRDATA = 0.
- Write to 32'h5000_0000 with HTRANS = NONSEQ -> HSEL_S = 4'b0100 in the address phase. Next cycle the mux selects slave 2, HREADY = 1, HRESP = 0.
- Read from 32'h2000_0004 while slave 1 drives HREADYOUT_S[1] low for 2 cycles and then returns 32'hDEAD_BEEF -> HREADY is low for 2 cycles, then HRDATA = 32'hDEAD_BEEF; sel_q stays at S1 throughout.
- NONSEQ to unmapped 32'h9000_0000 -> HSEL_S = 0. Next cycle HREADY = 0, HRESP = 1. The cycle after, HREADY = 1, HRESP = 1. Then OKAY.
- Two consecutive unmapped NONSEQs, the second presented in the ERR2 cycle -> sequence ERR1, ERR2, ERR1, ERR2. The second address is not sampled during ERR1.
- IDLE transfer to 32'h9000_0000 -> HREADY = 1, HRESP = 0 next cycle. Also: assert HRESETn = 0 during ERR1 -> HREADY = 1, HRESP = 0 immediately.
